change_dispenser: RTL and testbench

// - Downstream of vending_machine: takes the refund/change amount it produces at end of transaction and pays it out as physical coins.
// - Pays greedily, largest coin first (20, then 10, then 5), over a valid/ack handshake to the coin hopper.
// - Keeps a stock count per denomination and reports any amount it could not pay.
// - Coin encoding matches vending_machine money[2:0]: 3'b001=5, 3'b010=10, 3'b100=20.

---
 rtl/change_dispenser.sv | 204 ++++++++++++++++++++
 tb/tb_change_dispenser.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount out as coins, largest first (20/10/5),
// one coin at a time over a valid/ack handshake, tracking per-denomination stock.
// Optional build macro CHANGE_DISP_TIMEOUT_EN adds an ack timeout and a sticky jam flag.
// Coin encoding (one-hot): 3'b001 = 5, 3'b010 = 10, 3'b100 = 20.
module change_dispenser #(
   parameter int AMT_W       = 8,
   parameter int CNT_W       = 6,
   parameter int INIT_5      = 8,
   parameter int INIT_10     = 8,
   parameter int INIT_20     = 8,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             change_valid,
   input  logic [AMT_W-1:0] change_amt,
   output logic             change_ready,
   output logic [2:0]       coin_out,
   output logic             coin_valid,
   input  logic             coin_ack,
   input  logic             refill,
   input  logic [2:0]       refill_coin,
   output logic             done,
   output logic [AMT_W-1:0] short_amt,
   output logic             err_unaligned,
   output logic [CNT_W-1:0] stock_5,
   output logic [CNT_W-1:0] stock_10,
   output logic [CNT_W-1:0] stock_20
`ifdef CHANGE_DISP_TIMEOUT_EN
   ,
   output logic             jam
`endif
);

   typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

   localparam logic [CNT_W-1:0] STOCK_MAX = {CNT_W{1'b1}};

   state_t                       state_reg, state_next;
   logic [AMT_W-1:0]             rem_reg, rem_next;
   logic [2:0]                   sel_reg, sel_next;
   logic [AMT_W-1:0]             short_reg, short_next;
   logic                         err_reg, err_next;
   logic [2:0][CNT_W-1:0]        stock_reg, stock_next, stock_init;
   logic [2:0]                   pick;
   logic [AMT_W-1:0]             amt_mod5;
   logic [AMT_W-1:0]             amt_floor;
   logic                         refill_onehot;

`ifdef CHANGE_DISP_TIMEOUT_EN
   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   logic [TO_W-1:0]              to_cnt_reg, to_cnt_next;
   logic                         jam_reg, jam_next;
`endif

   // Face value of a one-hot coin code
   function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] c);
      case (c)
         3'b001:  coin_value = AMT_W'(5);
         3'b010:  coin_value = AMT_W'(10);
         3'b100:  coin_value = AMT_W'(20);
         default: coin_value = '0;
      endcase
   endfunction

   assign amt_mod5      = change_amt % AMT_W'(5);
   assign amt_floor     = change_amt - amt_mod5;
   assign refill_onehot = (refill_coin == 3'b001) || (refill_coin == 3'b010) ||
                          (refill_coin == 3'b100);

   // Per-denomination stock: refill adds, an acked coin removes, both together cancel
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stock
         localparam int INIT_V = (gi == 0) ? INIT_5 : (gi == 1) ? INIT_10 : INIT_20;
         logic inc, dec;
         assign inc = refill && refill_onehot && refill_coin[gi];
         assign dec = (state_reg == ISSUE) && coin_ack && sel_reg[gi];
         assign stock_init[gi] = CNT_W'(INIT_V);
         assign stock_next[gi] =
            (inc && !dec) ? ((stock_reg[gi] == STOCK_MAX) ? stock_reg[gi] : stock_reg[gi] + 1'b1) :
            (dec && !inc) ? stock_reg[gi] - 1'b1 :
                            stock_reg[gi];
      end
   endgenerate

   // Greedy choice from registered remainder and stock (refills this cycle not yet visible)
   always_comb begin
      pick = 3'b000;
      if (rem_reg >= AMT_W'(20) && stock_reg[2] != '0)
         pick = 3'b100;
      else if (rem_reg >= AMT_W'(10) && stock_reg[1] != '0)
         pick = 3'b010;
      else if (rem_reg >= AMT_W'(5) && stock_reg[0] != '0)
         pick = 3'b001;
   end

   // Next-state and datapath updates for the payout FSM
   always_comb begin
      state_next = state_reg;
      rem_next   = rem_reg;
      sel_next   = sel_reg;
      short_next = short_reg;
      err_next   = err_reg;
`ifdef CHANGE_DISP_TIMEOUT_EN
      to_cnt_next = to_cnt_reg;
      jam_next    = jam_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (change_valid) begin
               rem_next   = amt_floor;
               err_next   = (amt_mod5 != '0);
               short_next = '0;
               state_next = SELECT;
`ifdef CHANGE_DISP_TIMEOUT_EN
               // A jammed hopper pays nothing: report the whole amount as short
               if (jam_reg) begin
                  short_next = amt_floor;
                  state_next = DONE;
               end
`endif
            end
         end
         SELECT: begin
            if (rem_reg == '0) begin
               short_next = '0;
               state_next = DONE;
            end else if (pick != 3'b000) begin
               sel_next   = pick;
               state_next = ISSUE;
`ifdef CHANGE_DISP_TIMEOUT_EN
               to_cnt_next = '0;
`endif
            end else begin
               short_next = rem_reg;
               state_next = DONE;
            end
         end
         ISSUE: begin
            if (coin_ack) begin
               rem_next   = rem_reg - coin_value(sel_reg);
               sel_next   = 3'b000;
               state_next = SELECT;
            end
`ifdef CHANGE_DISP_TIMEOUT_EN
            else if (to_cnt_reg == TO_W'(ACK_TIMEOUT - 1)) begin
               jam_next   = 1'b1;
               short_next = rem_reg;
               sel_next   = 3'b000;
               state_next = DONE;
            end else begin
               to_cnt_next = to_cnt_reg + 1'b1;
            end
`endif
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any payout in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         rem_reg   <= '0;
         sel_reg   <= 3'b000;
         short_reg <= '0;
         err_reg   <= 1'b0;
         stock_reg <= stock_init;
`ifdef CHANGE_DISP_TIMEOUT_EN
         to_cnt_reg <= '0;
         jam_reg    <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         rem_reg   <= rem_next;
         sel_reg   <= sel_next;
         short_reg <= short_next;
         err_reg   <= err_next;
         stock_reg <= stock_next;
`ifdef CHANGE_DISP_TIMEOUT_EN
         to_cnt_reg <= to_cnt_next;
         jam_reg    <= jam_next;
`endif
      end
   end

   assign change_ready  = (state_reg == IDLE);
   assign coin_valid    = (state_reg == ISSUE);
   assign coin_out      = sel_reg;
   assign done          = (state_reg == DONE);
   assign short_amt     = short_reg;
   assign err_unaligned = err_reg;
   assign stock_5       = stock_reg[0];
   assign stock_10      = stock_reg[1];
   assign stock_20      = stock_reg[2];
`ifdef CHANGE_DISP_TIMEOUT_EN
   assign jam           = jam_reg;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser: table of payouts with hand-computed coin
// sequences and stock levels, plus directed sequences for the timing corners.
module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       reset;
   logic       change_valid;
   logic [7:0] change_amt;
   logic       change_ready;
   logic [2:0] coin_out;
   logic       coin_valid;
   logic       coin_ack;
   logic       refill;
   logic [2:0] refill_coin;
   logic       done;
   logic [7:0] short_amt;
   logic       err_unaligned;
   logic [5:0] stock_5, stock_10, stock_20;
`ifdef CHANGE_DISP_TIMEOUT_EN
   logic       jam;
`endif

   always #5 clk = ~clk;

   change_dispenser #(
      .AMT_W(8), .CNT_W(6), .INIT_5(4), .INIT_10(4), .INIT_20(4), .ACK_TIMEOUT(15)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .change_ready (change_ready),
      .coin_out     (coin_out),
      .coin_valid   (coin_valid),
      .coin_ack     (coin_ack),
      .refill       (refill),
      .refill_coin  (refill_coin),
      .done         (done),
      .short_amt    (short_amt),
      .err_unaligned(err_unaligned),
      .stock_5      (stock_5),
      .stock_10     (stock_10),
      .stock_20     (stock_20)
`ifdef CHANGE_DISP_TIMEOUT_EN
      ,
      .jam          (jam)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Results captured by pay()
   logic [2:0] got [16];
   int         got_n, got_short, got_err, first_it, done_it;

   typedef struct {
      int                amt;
      int                pre_r10;   // 10-coin refills applied before the payout
      int                n;
      logic [5:0][2:0]   coins;
      int                shrt;
      int                err;
      int                s5, s10, s20;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [5:0][2:0] cs(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c, input logic [2:0] d);
      logic [5:0][2:0] r;
      r = '0;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d;
      return r;
   endfunction

   task automatic do_refill(input logic [2:0] c);
      refill = 1'b1;
      refill_coin = c;
      @(negedge clk);
      refill = 1'b0;
      refill_coin = 3'b000;
   endtask

   // Accept one request and act as hopper: ack one cycle after a coin appears.
   // ack_refill: coin type to refill in the ack cycle; poke: request again during ISSUE.
   task automatic pay(input int amt, input logic [2:0] ack_refill, input bit poke);
      bit seen;
      got_n = 0; first_it = -1; done_it = -1; got_short = -1; got_err = -1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !change_ready; i++) @(negedge clk);
      change_valid = 1'b1;
      change_amt = 8'(amt);
      @(negedge clk);
      change_valid = 1'b0;
      change_amt = 8'd0;
      for (int it = 1; it <= 200; it++) begin
         refill = 1'b0;
         refill_coin = 3'b000;
         change_valid = 1'b0;
         if (done) begin
            done_it = it;
            got_short = int'(short_amt);
            got_err = int'(err_unaligned);
            break;
         end
         if (coin_ack) begin
            coin_ack = 1'b0;
            seen = 1'b0;
         end else if (coin_valid) begin
            if (!seen) begin
               if (got_n < 16) got[got_n] = coin_out;
               got_n++;
               if (first_it < 0) first_it = it;
               seen = 1'b1;
               if (poke && got_n == 1) begin
                  change_valid = 1'b1;
                  change_amt = 8'd5;
               end
            end else begin
               coin_ack = 1'b1;
               if (ack_refill != 3'b000) begin
                  refill = 1'b1;
                  refill_coin = ack_refill;
               end
            end
         end
         @(negedge clk);
      end
      check($sformatf("done_seen_amt%0d", amt), (done_it >= 0), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stimulus table: stocks start 4/4/4 and carry over from vector to vector
      vecs[0] = '{35, 0, 3, cs(3'b100, 3'b010, 3'b001, 3'b000), 0,  0, 3, 3, 3};
      vecs[1] = '{37, 0, 3, cs(3'b100, 3'b010, 3'b001, 3'b000), 0,  1, 2, 2, 2};
      vecs[2] = '{0,  0, 0, cs(3'b000, 3'b000, 3'b000, 3'b000), 0,  0, 2, 2, 2};
      vecs[3] = '{40, 0, 2, cs(3'b100, 3'b100, 3'b000, 3'b000), 0,  0, 2, 2, 0};
      vecs[4] = '{40, 2, 4, cs(3'b010, 3'b010, 3'b010, 3'b010), 0,  0, 2, 0, 0};
      vecs[5] = '{25, 0, 2, cs(3'b001, 3'b001, 3'b000, 3'b000), 15, 0, 0, 0, 0};
      vecs[6] = '{25, 1, 1, cs(3'b010, 3'b000, 3'b000, 3'b000), 15, 0, 0, 0, 0};

      reset = 1'b1; change_valid = 1'b0; change_amt = 8'd0;
      coin_ack = 1'b0; refill = 1'b0; refill_coin = 3'b000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", change_ready, 1);
      check("rst_coin_valid", coin_valid, 0);
      check("rst_coin_out", coin_out, 0);
      check("rst_done", done, 0);
      check("rst_short", short_amt, 0);
      check("rst_err", err_unaligned, 0);
      check("rst_stock5", stock_5, 4);
      check("rst_stock10", stock_10, 4);
      check("rst_stock20", stock_20, 4);

      for (int v = 0; v < 7; v++) begin
         for (int r = 0; r < vecs[v].pre_r10; r++) do_refill(3'b010);
         pay(vecs[v].amt, 3'b000, 1'b0);
         check($sformatf("v%0d_ncoins", v), got_n, vecs[v].n);
         for (int i = 0; i < vecs[v].n; i++)
            check($sformatf("v%0d_coin%0d", v, i), (i < got_n) ? 32'(got[i]) : 32'd0,
                  32'(vecs[v].coins[i]));
         check($sformatf("v%0d_short", v), got_short, vecs[v].shrt);
         check($sformatf("v%0d_err", v), got_err, vecs[v].err);
         check($sformatf("v%0d_stock5", v), stock_5, vecs[v].s5);
         check($sformatf("v%0d_stock10", v), stock_10, vecs[v].s10);
         check($sformatf("v%0d_stock20", v), stock_20, vecs[v].s20);
         if (vecs[v].n > 0)
            check($sformatf("v%0d_first_coin_lat", v), first_it, 2);
         else
            check($sformatf("v%0d_done_lat", v), done_it, 2);
         $display("vector %0d: amt=%0d coins=%0d short=%0d err=%0d stocks=%0d/%0d/%0d",
                  v, vecs[v].amt, got_n, got_short, got_err, stock_5, stock_10, stock_20);
      end

      // short_amt holds after done until the next accept
      @(negedge clk);
      check("short_hold_idle", short_amt, 15);

      // Non-one-hot refill is ignored; a valid one lands
      do_refill(3'b011);
      check("bad_refill_s5", stock_5, 0);
      check("bad_refill_s10", stock_10, 0);
      check("bad_refill_s20", stock_20, 0);
      do_refill(3'b001);
      check("good_refill_s5", stock_5, 1);
      $display("refill: stocks=%0d/%0d/%0d", stock_5, stock_10, stock_20);

      // Back to 4/4/4
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst2_stock5", stock_5, 4);

      // Refill of a 20 in the ack cycle of a 20; request during ISSUE is dropped
      pay(20, 3'b100, 1'b1);
      check("ack_refill_ncoins", got_n, 1);
      check("ack_refill_coin", 32'(got[0]), 32'(3'b100));
      check("ack_refill_short", got_short, 0);
      check("ack_refill_s20", stock_20, 4);
      begin
         int extra = 0;
         for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (coin_valid || done) extra++;
         end
         check("poke_ignored_activity", extra, 0);
      end
      check("poke_ignored_s5", stock_5, 4);
      $display("ack+refill: coins=%0d stock20=%0d", got_n, stock_20);

      // Reset during ISSUE of a pay 40
      change_valid = 1'b1;
      change_amt = 8'd40;
      @(negedge clk);
      change_valid = 1'b0;
      change_amt = 8'd0;
      for (int i = 0; i < 5 && !coin_valid; i++) @(negedge clk);
      check("midrst_in_issue", coin_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_coin_valid", coin_valid, 0);
      check("midrst_coin_out", coin_out, 0);
      check("midrst_ready", change_ready, 1);
      check("midrst_s5", stock_5, 4);
      check("midrst_s10", stock_10, 4);
      check("midrst_s20", stock_20, 4);
      $display("mid-payout reset: coin_valid=%0d ready=%0d", coin_valid, change_ready);

      // Refill saturation
      for (int i = 0; i < 70; i++) do_refill(3'b001);
      check("sat_s5", stock_5, 63);
      $display("saturation: stock5=%0d", stock_5);

`ifdef CHANGE_DISP_TIMEOUT_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      change_valid = 1'b1;
      change_amt = 8'd40;
      @(negedge clk);
      change_valid = 1'b0;
      change_amt = 8'd0;
      begin
         int seen_done = 0;
         for (int i = 0; i < 60 && !done; i++) @(negedge clk);
         seen_done = done;
         check("to_done", seen_done, 1);
      end
      check("to_short", short_amt, 40);
      check("to_jam", jam, 1);
      check("to_s20", stock_20, 4);
      $display("timeout: short=%0d jam=%0d", short_amt, jam);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
